// File: rtl/link_frame_if.sv
// Bundle of the two frame-source handshakes, the serial transmit handshake and
// the scheduler status outputs shared between link_frame_scheduler and its neighbours.
interface link_frame_if;
    logic [55:0] s0_frame;
    logic        s0_valid;
    logic        s0_ready;
    logic [55:0] s1_frame;
    logic        s1_valid;
    logic        s1_ready;
    logic        tx_bit;
    logic        tx_bit_valid;
    logic        tx_bit_ready;
    logic [1:0]  grant_id;
    logic [15:0] frames_sent;

    modport master (
        output s0_frame, s0_valid, s1_frame, s1_valid, tx_bit_ready,
        input  s0_ready, s1_ready, tx_bit, tx_bit_valid, grant_id, frames_sent
    );

    modport slave (
        input  s0_frame, s0_valid, s1_frame, s1_valid, tx_bit_ready,
        output s0_ready, s1_ready, tx_bit, tx_bit_valid, grant_id, frames_sent
    );
endinterface

// File: rtl/link_frame_scheduler.sv
// Frame-boundary arbiter between data (s0) and control (s1) sources with anti-starvation,
// MSB-first serializer; keepalive insertion on idle is built only with LINK_KEEPALIVE_EN.
module link_frame_scheduler #(
    parameter int unsigned MAX_STARVE      = 4,
    parameter logic [15:0] IDLE_TIMEOUT    = 16'd1000,
    parameter logic [55:0] KEEPALIVE_FRAME = 56'hAA_FF_00000000_00
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    link_frame_if.slave  lnk
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_SEND    = 1'b1;
    localparam logic [1:0] GID_S0     = 2'd0;
    localparam logic [1:0] GID_S1     = 2'd1;
    localparam logic [1:0] GID_KA     = 2'd2;
    localparam logic [1:0] GID_NONE   = 2'd3;
    localparam logic [7:0] STARVE_LIM = 8'(MAX_STARVE);

    logic [0:0]  state_r;
    logic [55:0] shift_r;
    logic [5:0]  bit_idx_r;
    logic [1:0]  grant_id_r;
    logic        tx_bit_valid_r;
    logic [15:0] frames_sent_r;
    logic [7:0]  starve_cnt_r;
    logic        ka_due_s;
    logic        pick_s0_s;
    logic        pick_s1_s;
    logic        pick_ka_s;
    logic        pick_any_s;
    logic [55:0] pick_frame_s;
    logic [1:0]  pick_gid_s;

`ifdef LINK_KEEPALIVE_EN
    logic [15:0] idle_cnt_r;

    assign ka_due_s = (idle_cnt_r == IDLE_TIMEOUT);

    // Idle counter: counts silent IDLE cycles, cleared by any grant and while sending
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= 16'd0;
        end else if ((state_r == ST_SEND) || pick_any_s) begin
            idle_cnt_r <= 16'd0;
        end else if (!lnk.s0_valid && !lnk.s1_valid) begin
            idle_cnt_r <= idle_cnt_r + 16'd1;
        end
    end
`else
    logic ka_unused_s;
    assign ka_unused_s = ^IDLE_TIMEOUT;
    assign ka_due_s    = 1'b0;
`endif

    // Arbitration: only in IDLE (and out of reset); s1 wins when s0 is absent or s1 is starved
    always_comb begin
        pick_s0_s = 1'b0;
        pick_s1_s = 1'b0;
        pick_ka_s = 1'b0;
        if (rst_n && (state_r == ST_IDLE)) begin
            if (lnk.s1_valid && (!lnk.s0_valid || (starve_cnt_r == STARVE_LIM))) begin
                pick_s1_s = 1'b1;
            end else if (lnk.s0_valid) begin
                pick_s0_s = 1'b1;
            end else begin
                pick_ka_s = ka_due_s;
            end
        end else begin
            pick_s0_s = 1'b0;
            pick_s1_s = 1'b0;
            pick_ka_s = 1'b0;
        end
    end

    // Frame and owner selected by the arbiter
    always_comb begin
        pick_frame_s = KEEPALIVE_FRAME;
        pick_gid_s   = GID_KA;
        if (pick_s1_s) begin
            pick_frame_s = lnk.s1_frame;
            pick_gid_s   = GID_S1;
        end else if (pick_s0_s) begin
            pick_frame_s = lnk.s0_frame;
            pick_gid_s   = GID_S0;
        end else begin
            pick_frame_s = KEEPALIVE_FRAME;
            pick_gid_s   = GID_KA;
        end
    end

    assign pick_any_s = pick_s0_s | pick_s1_s | pick_ka_s;

    // Frame FSM and serializer: load on grant, shift on each encoder handshake
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            shift_r        <= 56'd0;
            bit_idx_r      <= 6'd0;
            grant_id_r     <= GID_NONE;
            tx_bit_valid_r <= 1'b0;
            frames_sent_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        shift_r        <= pick_frame_s;
                        bit_idx_r      <= 6'd0;
                        grant_id_r     <= pick_gid_s;
                        tx_bit_valid_r <= 1'b1;
                        state_r        <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (lnk.tx_bit_ready) begin
                        shift_r   <= {shift_r[54:0], 1'b0};
                        bit_idx_r <= bit_idx_r + 6'd1;
                        if (bit_idx_r == 6'd55) begin
                            frames_sent_r  <= frames_sent_r + 16'd1;
                            grant_id_r     <= GID_NONE;
                            tx_bit_valid_r <= 1'b0;
                            state_r        <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    grant_id_r     <= GID_NONE;
                    tx_bit_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: consecutive s0 grants taken while s1 was waiting
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= 8'd0;
        end else if (pick_s1_s) begin
            starve_cnt_r <= 8'd0;
        end else if (pick_s0_s) begin
            if (!lnk.s1_valid) begin
                starve_cnt_r <= 8'd0;
            end else if (starve_cnt_r != STARVE_LIM) begin
                starve_cnt_r <= starve_cnt_r + 8'd1;
            end
        end
    end

    assign lnk.s0_ready     = pick_s0_s;
    assign lnk.s1_ready     = pick_s1_s;
    assign lnk.tx_bit       = shift_r[55];
    assign lnk.tx_bit_valid = tx_bit_valid_r;
    assign lnk.grant_id     = grant_id_r;
    assign lnk.frames_sent  = frames_sent_r;
endmodule

// File: tb/tb_link_frame_scheduler.sv
// Randomized bench for link_frame_scheduler against a queue-based link model.
module tb_link_frame_scheduler;
    localparam int          MAX_ST = 4;
    localparam logic [15:0] IDLE_TO = 16'd10;
    localparam logic [55:0] KA = 56'hAA_FF_00000000_00;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    link_frame_if lnk();

    link_frame_scheduler #(.MAX_STARVE(MAX_ST), .IDLE_TIMEOUT(IDLE_TO), .KEEPALIVE_FRAME(KA)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .lnk(lnk)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;
    bit      mq[$];
    int      obs_q[$];
    logic [1:0]  m_gid;
    logic [15:0] m_sent;
    int m_starve, m_idle, last_pick, cyc;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [55:0] rnd_frame();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[55:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_gid = 2'd3; m_sent = 16'd0; m_starve = 0; m_idle = 0; last_pick = -1;
    endtask

    // One clock: compare DUT against the model (at negedge+1), advance the model, wait next negedge
    task automatic cycle();
        int pk;
        logic [55:0] f;
        pk = -1;
        #1;
        if (mq.size() == 0) begin
            if (lnk.s1_valid && (!lnk.s0_valid || m_starve == MAX_ST)) pk = 1;
            else if (lnk.s0_valid) pk = 0;
`ifdef LINK_KEEPALIVE_EN
            else if (m_idle == int'(IDLE_TO)) pk = 2;
`endif
        end
        check_val("s0_ready", 64'(lnk.s0_ready), 64'(pk == 0));
        check_val("s1_ready", 64'(lnk.s1_ready), 64'(pk == 1));
        check_val("tx_bit_valid", 64'(lnk.tx_bit_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) check_val("tx_bit", 64'(lnk.tx_bit), 64'(mq[0]));
        check_val("grant_id", 64'(lnk.grant_id), 64'(m_gid));
        check_val("frames_sent", 64'(lnk.frames_sent), 64'(m_sent));
        if (lnk.s0_ready) obs_q.push_back(0);
        else if (lnk.s1_ready) obs_q.push_back(1);
        if (mq.size() > 0 || pk >= 0) m_idle = 0;
        else if (!lnk.s0_valid && !lnk.s1_valid) m_idle++;
        if (pk >= 0) begin
            f = (pk == 0) ? lnk.s0_frame : (pk == 1) ? lnk.s1_frame : KA;
            for (int i = 55; i >= 0; i--) mq.push_back(f[i]);
            m_gid = 2'(pk);
            if (pk == 1) m_starve = 0;
            else if (pk == 0) m_starve = lnk.s1_valid ? ((m_starve < MAX_ST) ? m_starve + 1 : MAX_ST) : 0;
        end else if (mq.size() > 0 && lnk.tx_bit_ready) begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
                m_sent = m_sent + 16'd1;
                m_gid  = 2'd3;
            end
        end
        last_pick = pk;
        cyc++;
        @(negedge clk_sys);
    endtask

    // Asynchronous reset pulse from a negedge; reset values are checked while rst_n is low
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_tx_valid", 64'(lnk.tx_bit_valid), 64'd0);
        check_val("rst_tx_bit", 64'(lnk.tx_bit), 64'd0);
        check_val("rst_grant_id", 64'(lnk.grant_id), 64'd3);
        check_val("rst_frames_sent", 64'(lnk.frames_sent), 64'd0);
        check_val("rst_s0_ready", 64'(lnk.s0_ready), 64'd0);
        check_val("rst_s1_ready", 64'(lnk.s1_ready), 64'd0);
        model_reset();
        @(negedge clk_sys);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        lnk.s0_frame = 56'd0; lnk.s0_valid = 1'b0;
        lnk.s1_frame = 56'd0; lnk.s1_valid = 1'b0;
        lnk.tx_bit_ready = 1'b1;
        cyc = 0;
        model_reset();
        @(negedge clk_sys);
        do_reset();

        // Single frame with the encoder always ready
        lnk.s0_frame = 56'hAA_00_DEADBEEF_5C;
        lnk.s0_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            cycle();
            if (last_pick == 0) lnk.s0_valid = 1'b0;
        end
        check_val("single_frames_sent", 64'(lnk.frames_sent), 64'd1);
        check_val("single_grant_none", 64'(lnk.grant_id), 64'd3);

`ifdef LINK_KEEPALIVE_EN
        // Keepalive after IDLE_TIMEOUT silent cycles following reset
        do_reset();
        for (int k = 0; k < 80; k++) begin
            cycle();
            if (cyc == 12) check_val("ka_grant_id", 64'(lnk.grant_id), 64'd2);
        end
        check_val("ka_frames_sent", 64'(lnk.frames_sent), 64'd1);
`else
        // Without keepalive the link stays silent
        for (int k = 0; k < 1000; k++) begin
            if (lnk.tx_bit_valid) check_val("silent_tx_valid", 64'(lnk.tx_bit_valid), 64'd0);
            cycle();
        end
        check_val("silent_frames_sent", 64'(lnk.frames_sent), 64'd1);
`endif

        // Starvation: both sources permanently requesting
        do_reset();
        obs_q.delete();
        lnk.s0_frame = rnd_frame(); lnk.s0_valid = 1'b1;
        lnk.s1_frame = rnd_frame(); lnk.s1_valid = 1'b1;
        for (int k = 0; k < 600; k++) begin
            cycle();
            if (last_pick == 0) lnk.s0_frame = rnd_frame();
            if (last_pick == 1) lnk.s1_frame = rnd_frame();
        end
        check_val("starve_grants", 64'(obs_q.size() >= 10), 64'd1);
        for (int i = 0; i < 10 && i < obs_q.size(); i++)
            check_val("starve_order", 64'(obs_q[i]), 64'((i % 5 == 4) ? 1 : 0));

        // Random traffic with encoder backpressure
        lnk.s0_valid = 1'b0; lnk.s1_valid = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            lnk.tx_bit_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (last_pick == 0) lnk.s0_valid = 1'b0;
            if (last_pick == 1) lnk.s1_valid = 1'b0;
            if (!lnk.s0_valid && $urandom_range(0, 3) == 0) begin
                lnk.s0_frame = rnd_frame(); lnk.s0_valid = 1'b1;
            end
            if (!lnk.s1_valid && $urandom_range(0, 9) == 0) begin
                lnk.s1_frame = rnd_frame(); lnk.s1_valid = 1'b1;
            end
        end

        // Reset during a frame, then a pending s1 frame is sent whole
        lnk.tx_bit_ready = 1'b1;
        lnk.s0_valid = 1'b0; lnk.s1_valid = 1'b0;
        for (int k = 0; k < 200 && mq.size() > 0; k++) cycle();
        lnk.s0_frame = rnd_frame(); lnk.s0_valid = 1'b1;
        for (int k = 0; k < 100 && mq.size() != 36; k++) begin
            cycle();
            if (last_pick == 0) lnk.s0_valid = 1'b0;
        end
        check_val("reach_bit20", 64'(mq.size()), 64'd36);
        lnk.s1_frame = rnd_frame(); lnk.s1_valid = 1'b1;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            cycle();
            if (last_pick == 1) lnk.s1_valid = 1'b0;
        end
        check_val("after_rst_frames_sent", 64'(lnk.frames_sent), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/link_frame_scheduler.md
# link_frame_scheduler

Frame-level scheduler that shares the single bit-serial transmit path toward the Manchester encoder between two frame sources: the data-frame stream and the low-rate control/status stream. Each source presents pre-assembled 56-bit frames ({SYNC, CNT, DATA, CRC}). The block grants the link at frame boundaries only, with anti-starvation, and serializes the granted frame MSB-first. Optionally it inserts keepalive frames when the link sits idle. It lives entirely in the clk_sys (100 MHz) domain, downstream of the frame assembly logic and upstream of the line encoder.

## Interface
- `MAX_STARVE`, default 4: consecutive port-0 grants allowed while port 1 waits (1–255).
- `IDLE_TIMEOUT`, default 16'd1000: idle IDLE-state cycles before a keepalive is sent (≥1).
- `KEEPALIVE_FRAME`, default 56'hAA_FF_00000000_00: frame sent as keepalive.
- `clk_sys`  in  1  100 MHz system clock.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `s0_frame`  in  56  Data-source frame.
- `s0_valid`  in  1  Data frame available.
- `s0_ready`  out  1  Data frame accepted this cycle.
- `s1_frame`  in  56  Control-source frame.
- `s1_valid`  in  1  Control frame available.
- `s1_ready`  out  1  Control frame accepted this cycle.
- `tx_bit`  out  1  Serial bit, MSB first.
- `tx_bit_valid`  out  1  `tx_bit` is valid.
- `tx_bit_ready`  in  1  Encoder consumes a bit when valid & ready.
- `grant_id`  out  2  Current owner: 0 = s0, 1 = s1, 2 = keepalive, 3 = none.
- `frames_sent`  out  16  Completed frames; wraps at 0xFFFF→0.

## Operation
- States: IDLE, SEND. Reset enters IDLE.
- IDLE selection, evaluated each cycle:
  - If `s1_valid` and (`!s0_valid` or `starve_cnt == MAX_STARVE`), pick s1.
  - Else if `s0_valid`, pick s0.
  - Else keepalive, if that is due.
- `sX_ready` is combinational: high only in IDLE when X is picked. The transfer happens in that cycle.
- On a pick:
  - Load the frame into `shift_reg[55:0]`.
  - Set `bit_idx` to 0.
  - Set `grant_id` to the picked owner.
  - Go to SEND.
- `starve_cnt` (8-bit) update at each grant:
  - s0 granted while `s1_valid` is high: increment, saturating at `MAX_STARVE`.
  - s1 granted: clear.
  - s0 granted while `s1_valid` is low: clear.
- SEND:
  - `tx_bit_valid` is held at 1 and `tx_bit` = `shift_reg[55]`.
  - On `tx_bit_ready`: shift left 1 and increment `bit_idx`.
  - If `bit_idx` is 55 on that handshake:
    - Increment `frames_sent`.
    - Set `grant_id` to 3.
    - Go to IDLE.
  - While `tx_bit_ready` is low, hold everything.
- `sX_ready` is 0 throughout SEND. New valids never preempt a frame in flight.

## Timing
- Reset values (async, immediate):
  - `tx_bit` 0, `tx_bit_valid` 0, `grant_id` 3, `frames_sent` 0.
  - `s0_ready` 0, `s1_ready` 0.
  - `starve_cnt` 0, idle counter 0.
- Reset mid-frame discards the partial frame. Those bits are not re-sent.
- Accept at cycle N puts bit 55 on `tx_bit` with `tx_bit_valid` = 1 at N+1.
- With `tx_bit_ready` tied high:
  - The last bit is presented at N+56.
  - The state is IDLE at N+57, where the next accept can occur.
  - Sustained rate is 56 bits per 57 cycles.
- `tx_bit_valid` deasserts in the cycle after the final handshake.
- `tx_bit` and `tx_bit_valid` are registered outputs. `sX_ready` is combinational from state and valids.
- Both valids rising in the same IDLE cycle: s0 wins unless the starvation limit has been reached.
- Sources must hold frame and valid stable until ready (standard valid/ready).

## Configuration
- `LINK_KEEPALIVE_EN` defined:
  - An idle counter (16-bit) increments on each IDLE cycle with both valids low.
  - It clears on any grant and throughout SEND.
  - When it equals `IDLE_TIMEOUT` and both valids are low, load `KEEPALIVE_FRAME` with `grant_id` = 2. It then serializes like a normal frame and counts in `frames_sent`.
  - A real valid in the same cycle takes precedence and clears the counter.
- `LINK_KEEPALIVE_EN` undefined:
  - No idle counter is built.
  - The link stays silent (`tx_bit_valid` = 0) while there are no requests.
  - `grant_id` never takes the value 2.

## Test plan
- **Single frame:** reset, then `s0_frame` = 56'hAA_00_DEADBEEF_5C with `s0_valid`, `tx_bit_ready` = 1.
  - `s0_ready` pulses for 1 cycle.
  - 56 bits come out MSB-first starting next cycle, matching the frame.
  - `frames_sent` = 1 and `grant_id` returns to 3.
- **Backpressure:** toggle `tx_bit_ready` pseudo-randomly during a frame.
  - The bit sequence is unchanged and no bit is dropped or duplicated.
  - `tx_bit` is stable while ready is low.
- **Starvation:** `s0_valid` and `s1_valid` held high continuously, `MAX_STARVE` = 4.
  - Grant order is s0,s0,s0,s0,s1, repeating.
  - `s1` is never blocked for more than 4 frames.
- **Keepalive** (macro on, `IDLE_TIMEOUT` = 10): no valids after reset.
  - The first `KEEPALIVE_FRAME` bit appears after 10 idle cycles, with `grant_id` = 2.
  - With the macro off, `tx_bit_valid` stays 0 for 1000 cycles.
- **Reset mid-frame:** assert `rst_n` low at bit 20.
  - Outputs go to reset values asynchronously and `frames_sent` = 0.
  - After release, a pending `s1` frame is sent whole from bit 55.
- **Counter wrap:** preload or run 65536 frames.
  - `frames_sent` wraps 0xFFFF→0x0000 without affecting the grant sequence.
